mac_lane_stream: RTL and testbench

- Parametrised streaming dot-product lane and successor to the fixed 16-lane MAC lane.
- Multiplies LANES input/weight pairs, reduces them through a registered adder tree, and stochastically rounds the sum to Q(IL.FL).
- Accumulates rounded partial sums across a framed group of beats (first/last), then emits one result with optional ReLU and a valid pulse.
- Sits between the operand fetch buffers and the activation writeback in the PE array.

---
 rtl/mac_lane_stream_pkg.sv | 43 ++++
 rtl/mac_lane_stream_if.sv | 24 ++
 rtl/mac_lane_stream_adder_tree.sv | 47 ++++
 rtl/mac_lane_stream.sv | 137 +++++++++++++
 tb/tb_mac_lane_stream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_lane_stream_pkg.sv
// Shared types and helpers for the streaming MAC lane: beat flags, width helpers,
// W-bit saturation and the 16-bit rounding LFSR step.
package mac_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic relu;
    } beat_flags_t;

    function automatic int unsigned data_w(input int unsigned il, input int unsigned fl);
        return il + fl;
    endfunction

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned sum_w(input int unsigned w, input int unsigned lanes);
        return 2 * w + $clog2(lanes);
    endfunction

    // Clamp a sign-extended value into the signed w-bit range.
    function automatic longint sat_w(input longint x, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11, feedback shifted into bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mac_lane_stream_if.sv
// Beat/result bus of the MAC lane: operand fetch side drives beats, lane returns results.
interface mac_lane_stream_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned W     = 20
);
    logic                   in_valid;
    logic                   in_first;
    logic                   in_last;
    logic                   relu_en;
    logic [LANES*W-1:0]     i_vec;
    logic [LANES*W-1:0]     w_vec;
    logic                   out_valid;
    logic signed [W-1:0]    out_data;

    modport master (
        output in_valid, in_first, in_last, relu_en, i_vec, w_vec,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_first, in_last, relu_en, i_vec, w_vec,
        output out_valid, out_data
    );
endinterface

// File: rtl/mac_lane_stream_adder_tree.sv
// Fully registered binary adder tree: log2(LANES) stages, one bit of growth per level,
// beat flags travel in lockstep with the partial sums.
module adder_tree_param
    import mac_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned IN_W  = 40
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  beat_flags_t                           flags_i,
    input  logic [LANES*IN_W-1:0]                 data_i,
    output beat_flags_t                           flags_o,
    output logic signed [IN_W+$clog2(LANES)-1:0]  sum_o
);
    localparam int unsigned L = $clog2(LANES);

    for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
        localparam int unsigned NW = IN_W + lv;
        localparam int unsigned NN = LANES >> lv;

        logic signed [NW-1:0] node [NN];
        beat_flags_t          flg;

        if (lv == 0) begin : g_leaf
            for (genvar n = 0; n < NN; n++) begin : g_in
                assign node[n] = data_i[n*IN_W +: IN_W];
            end
            assign flg = flags_i;
        end else begin : g_sum
            always_ff @(posedge clk) begin
                if (reset) begin
                    flg <= '0;
                end else begin
                    flg <= g_lvl[lv-1].flg;
                end
                for (int unsigned j = 0; j < NN; j++) begin
                    node[j] <= NW'(g_lvl[lv-1].node[2*j]) + NW'(g_lvl[lv-1].node[2*j+1]);
                end
            end
        end
    end

    assign sum_o   = g_lvl[L].node[0];
    assign flags_o = g_lvl[L].flg;

endmodule

// File: rtl/mac_lane_stream.sv
// Streaming dot-product lane: multiply, registered tree reduce, stochastic round to Q(IL.FL),
// framed accumulate with optional ReLU. Define MAC_LANE_STREAM_SAT_EN for a saturating accumulator.
module mac_lane_stream
    import mac_pkg::*;
#(
    parameter int unsigned IL        = 8,
    parameter int unsigned FL        = 12,
    parameter int unsigned LANES     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic              clk,
    input logic              reset,
    mac_lane_stream_if.slave bus
);
    localparam int unsigned W  = data_w(IL, FL);
    localparam int unsigned PW = prod_w(W);
    localparam int unsigned SW = sum_w(W, LANES);
    localparam int unsigned RW = SW + 1;

    beat_flags_t            s1_flags_q;
    beat_flags_t            s2_flags_q;
    beat_flags_t            tree_flags;
    beat_flags_t            r1_flags_q;
    beat_flags_t            r2_flags_q;
    logic [LANES*W-1:0]     s1_i_q;
    logic [LANES*W-1:0]     s1_w_q;
    logic [LANES*PW-1:0]    s2_prod_q;
    logic signed [SW-1:0]   tree_sum;
    logic signed [RW-1:0]   r1_sum_q;
    logic signed [RW-1:0]   r1_shift;
    logic signed [W-1:0]    r2_term_q;
    logic [15:0]            lfsr_q;
    logic [15:0]            lfsr_d;
    logic signed [W-1:0]    acc_q;
    logic signed [W-1:0]    acc_d;
    logic signed [W-1:0]    acc_base;
    logic signed [W-1:0]    out_data_q;
    logic signed [W-1:0]    out_data_d;
    logic                   out_valid_q;
    logic                   out_valid_d;

    // Control flags are qualified by in_valid here so downstream stages only look at .valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_flags_q <= '0;
        end else begin
            s1_flags_q <= '{valid: bus.in_valid,
                            first: bus.in_valid & bus.in_first,
                            last:  bus.in_valid & bus.in_last,
                            relu:  bus.in_valid & bus.relu_en};
        end
        s1_i_q <= bus.i_vec;
        s1_w_q <= bus.w_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_flags_q <= '0;
        end else begin
            s2_flags_q <= s1_flags_q;
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            s2_prod_q[k*PW +: PW] <= PW'($signed(s1_i_q[k*W +: W])) * PW'($signed(s1_w_q[k*W +: W]));
        end
    end

    adder_tree_param #(
        .LANES (LANES),
        .IN_W  (PW)
    ) u_tree (
        .clk     (clk),
        .reset   (reset),
        .flags_i (s2_flags_q),
        .data_i  (s2_prod_q),
        .flags_o (tree_flags),
        .sum_o   (tree_sum)
    );

    // Rounding is split: dither add registered here, shift/saturate in the next stage.
    assign lfsr_d = tree_flags.valid ? lfsr16_next(lfsr_q) : lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_flags_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            r1_flags_q <= tree_flags;
            lfsr_q     <= lfsr_d;
        end
        r1_sum_q <= RW'(tree_sum) + RW'(lfsr_q[FL-1:0]);
    end

    assign r1_shift = r1_sum_q >>> FL;

    always_ff @(posedge clk) begin
        if (reset) begin
            r2_flags_q <= '0;
        end else begin
            r2_flags_q <= r1_flags_q;
        end
        r2_term_q <= W'(sat_w(64'(r1_shift), W));
    end

    always_comb begin
        acc_base    = r2_flags_q.first ? '0 : acc_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (r2_flags_q.valid) begin
`ifdef MAC_LANE_STREAM_SAT_EN
            acc_d = W'(sat_w(longint'(acc_base) + longint'(r2_term_q), W));
`else
            acc_d = acc_base + r2_term_q;
`endif
            if (r2_flags_q.last) begin
                out_valid_d = 1'b1;
                out_data_d  = (r2_flags_q.relu && acc_d[W-1]) ? '0 : acc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mac_lane_stream.sv
// Scoreboard bench for mac_lane_stream: a plain-arithmetic group model pushes expected
// results with their due cycle; a negedge monitor pops and compares each output pulse.
module tb_mac_lane_stream;
    localparam int unsigned IL    = 8;
    localparam int unsigned FL    = 12;
    localparam int unsigned LANES = 16;
    localparam int unsigned W     = IL + FL;
    localparam int unsigned L     = $clog2(LANES);
    localparam int          LAT   = int'(L) + 5;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam longint      ONE   = 64'sd4096;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    mac_lane_stream_if #(.LANES(LANES), .W(W)) bus ();

    mac_lane_stream #(
        .IL        (IL),
        .FL        (FL),
        .LANES     (LANES),
        .LFSR_SEED (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint data;
        int     cyc;
        string  tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    longint      last_out = 0;
    longint      m_acc = 0;
    logic [15:0] m_lfsr = SEED;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference arithmetic on plain integers.
    function automatic longint clampw(input longint x);
        longint hi;
        hi = (longint'(1) << (W - 1)) - 1;
        if (x > hi) return hi;
        if (x < -hi - 1) return -hi - 1;
        return x;
    endfunction

    function automatic longint wrapw(input longint x);
        longint m;
        m = x & ((longint'(1) << W) - 1);
        if (m >= (longint'(1) << (W - 1))) m -= (longint'(1) << W);
        return m;
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    function automatic logic [LANES*W-1:0] splat(input longint val, input int n);
        logic [LANES*W-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*W +: W] = W'(val);
        return v;
    endfunction

    function automatic logic [LANES*W-1:0] rand_vec(input bit big);
        logic [LANES*W-1:0] v;
        for (int k = 0; k < int'(LANES); k++) begin
            if (big) v[k*W +: W] = W'($urandom);
            else     v[k*W +: W] = W'(int'($urandom_range(0, 16383)) - 8192);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b1 && bus.out_valid === 1'b1) begin
            last_out = longint'(bus.out_data);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_out_valid: got out_data %0d, expected no pulse (cycle %0d)", last_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_data"}, last_out, e.data);
                check({e.tag, "_cycle"}, longint'(cyc), longint'(e.cyc));
            end
        end else if (reset !== 1'b1 && exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            $display("FAIL %s_missing: got no out_valid, expected %0d at cycle %0d", e.tag, e.data, e.cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b0;
            bus.in_first = 1'($urandom);
            bus.in_last  = 1'($urandom);
            bus.relu_en  = 1'($urandom);
            bus.i_vec    = rand_vec(1'b0);
            bus.w_vec    = rand_vec(1'b0);
            tick();
        end
    endtask

    task automatic beat(input logic [LANES*W-1:0] iv, input logic [LANES*W-1:0] wv,
                        input bit first, input bit last, input bit relu, input string tag);
        longint s;
        longint t;
        longint a;
        exp_t   e;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        bus.relu_en  = relu;
        bus.i_vec    = iv;
        bus.w_vec    = wv;
        s = 0;
        for (int k = 0; k < int'(LANES); k++)
            s += longint'($signed(iv[k*W +: W])) * longint'($signed(wv[k*W +: W]));
        t = (s + (longint'(m_lfsr) % (longint'(1) << FL))) >>> FL;
        m_lfsr = ref_lfsr(m_lfsr);
        t = clampw(t);
        a = (first ? 0 : m_acc) + t;
`ifdef MAC_LANE_STREAM_SAT_EN
        a = clampw(a);
`else
        a = wrapw(a);
`endif
        m_acc = a;
        if (last) begin
            e.data = (relu && a < 0) ? 0 : a;
            e.cyc  = cyc + LAT;
            e.tag  = tag;
            exp_q.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        m_acc  = 0;
        m_lfsr = SEED;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        int len;
        bit cont;
        bit big;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.relu_en  = 1'b0;
        bus.i_vec    = '0;
        bus.w_vec    = '0;
        do_reset(3);
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_out_data", longint'(bus.out_data), 0);

        beat(splat(ONE, LANES), splat(2 * ONE, LANES), 1, 1, 0, "all_ones");
        idle(12);

        for (int b = 0; b < 4; b++) beat(splat(ONE, 1), splat(-3 * ONE, 1), b == 0, b == 3, 0, "neg_group");
        for (int b = 0; b < 4; b++) beat(splat(ONE, 1), splat(-3 * ONE, 1), b == 0, b == 3, b == 3, "relu_group");
        idle(2);

        beat(splat(ONE, 1), splat(ONE, 1), 1, 0, 0, "b2b_a");
        beat(splat(ONE, 1), splat(ONE, 1), 0, 1, 0, "b2b_a");
        beat(splat(5 * ONE, 1), splat(ONE, 1), 1, 1, 0, "b2b_b");
        beat(splat(ONE, 1), splat(ONE, 1), 0, 1, 0, "continue");
        idle(LAT + 2);
        check("hold_out_data", longint'(bus.out_data), 6 * ONE);

        beat(splat(127 * ONE, LANES), splat(ONE, LANES), 1, 1, 0, "ovf_term");
        beat(splat(127 * ONE, LANES), splat(ONE, LANES), 0, 1, 0, "ovf_acc");
        idle(LAT + 2);

        beat(splat(ONE, 1), splat(ONE, 1), 1, 1, 0, "pre_reset");
        idle(3);
        do_reset(2);
        idle(LAT + 3);
        beat(splat(ONE, LANES), splat(2 * ONE, LANES), 1, 1, 0, "post_reset");
        idle(4);

        for (int g = 0; g < 40; g++) begin
            len  = int'($urandom_range(1, 4));
            cont = ($urandom_range(0, 7) == 0);
            big  = 1'($urandom);
            for (int b = 0; b < len; b++) begin
                beat(rand_vec(big), rand_vec(big), (b == 0) && !cont, b == len - 1, 1'($urandom), "rand");
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        idle(LAT + 2);

        for (int b = 0; b < 1000; b++) beat(splat(201, 1), splat(2048, 1), b == 0, b == 999, 0, "sr_mean");
        for (int k = 0; k < 4 * LAT && exp_q.size() != 0; k++) tick();
        check("queue_drained", longint'(exp_q.size()), 0);
        checks++;
        if (last_out >= 100500 - 2010 && last_out <= 100500 + 2010) passed++;
        else $display("FAIL sr_mean_range: got %0d, expected 98490..102510", last_out);

        idle(3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
